// File: rtl/ep2_stream_pkg.sv
// ep2_stream_pkg: shared types and helpers for the EP2 stream stages.
//  - emit_state_t   : emit stage state machine encoding
//  - DEF_* widths   : default stream/struct widths used by the stages
//  - keep_width()   : KW derivation from a data width
//  - struct_bytes() : SB derivation from a struct width
//  - keep_overflow(): reports whether the top SB keep bits of a beat are set,
//                     i.e. whether prepending SB bytes spills into another beat
package ep2_stream_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FORWARD = 2'd1,
        FLUSH   = 2'd2
    } emit_state_t;

    localparam int DEF_DATA_WIDTH   = 256;
    localparam int DEF_STRUCT_WIDTH = 16;
    // Widest keep vector the helper accepts (1024-bit streams).
    localparam int KEEP_MAX         = 128;

    function automatic int keep_width(input int dw);
        return dw / 8;
    endfunction

    function automatic int struct_bytes(input int sw);
        return sw / 8;
    endfunction

    // keep is zero-extended to KEEP_MAX by the caller; kw is the real keep width.
    function automatic logic keep_overflow(input logic [KEEP_MAX-1:0] keep,
                                           input int kw, input int sb);
        logic ovf;
        ovf = 1'b0;
        for (int i = 0; i < KEEP_MAX; i++) begin
            if (i >= kw - sb && i < kw) begin
                ovf = ovf | keep[i];
            end
        end
        return ovf;
    endfunction

endpackage

// File: rtl/axis_register.sv
// axis_register: one-stage AXI-Stream register slice.
//  REG_TYPE 0 : combinational bypass.
//  other      : skid buffer; s_axis_tready is a register output, full throughput,
//               m_axis_* held stable while m_axis_tvalid & !m_axis_tready.
//  KEEP_ENABLE / LAST_ENABLE = 0 tie m_axis_tkeep to all ones / m_axis_tlast to 0.
// Ports: clk, rst (sync, active-high), s_axis_{tdata,tkeep,tvalid,tready,tlast},
//        m_axis_{tdata,tkeep,tvalid,tready,tlast}.
// Handshake: a beat transfers on a rising clk edge where tvalid & tready are both 1;
//            a source never withdraws tvalid or changes its payload until it transfers.
module axis_register #(
    parameter int DATA_WIDTH  = 8,
    parameter int KEEP_ENABLE = 1,
    parameter int KEEP_WIDTH  = DATA_WIDTH / 8,
    parameter int LAST_ENABLE = 1,
    parameter int REG_TYPE    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tlast,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast
);

    logic [DATA_WIDTH-1:0] out_data;
    logic [KEEP_WIDTH-1:0] out_keep;
    logic                  out_last;
    logic                  out_valid;

    generate
        if (REG_TYPE == 0) begin : g_bypass
            assign out_data      = s_axis_tdata;
            assign out_keep      = s_axis_tkeep;
            assign out_last      = s_axis_tlast;
            assign out_valid     = s_axis_tvalid;
            assign s_axis_tready = m_axis_tready;
        end else begin : g_skid
            logic [DATA_WIDTH-1:0] out_data_r, skid_data;
            logic [KEEP_WIDTH-1:0] out_keep_r, skid_keep;
            logic                  out_last_r, skid_last;
            logic                  out_valid_r, skid_valid;

            // The skid slot catches the one beat accepted while the output stalls.
            always_ff @(posedge clk) begin
                if (rst) begin
                    out_valid_r <= 1'b0;
                    skid_valid  <= 1'b0;
                    out_data_r  <= '0;
                    out_keep_r  <= '0;
                    out_last_r  <= 1'b0;
                    skid_data   <= '0;
                    skid_keep   <= '0;
                    skid_last   <= 1'b0;
                end else if (!out_valid_r || m_axis_tready) begin
                    if (skid_valid) begin
                        out_valid_r <= 1'b1;
                        skid_valid  <= 1'b0;
                        out_data_r  <= skid_data;
                        out_keep_r  <= skid_keep;
                        out_last_r  <= skid_last;
                    end else begin
                        out_valid_r <= s_axis_tvalid;
                        if (s_axis_tvalid) begin
                            out_data_r <= s_axis_tdata;
                            out_keep_r <= s_axis_tkeep;
                            out_last_r <= s_axis_tlast;
                        end
                    end
                end else if (s_axis_tvalid && !skid_valid) begin
                    skid_valid <= 1'b1;
                    skid_data  <= s_axis_tdata;
                    skid_keep  <= s_axis_tkeep;
                    skid_last  <= s_axis_tlast;
                end
            end

            assign out_data      = out_data_r;
            assign out_keep      = out_keep_r;
            assign out_last      = out_last_r;
            assign out_valid     = out_valid_r;
            assign s_axis_tready = !skid_valid;
        end
    endgenerate

    assign m_axis_tdata  = out_data;
    assign m_axis_tkeep  = (KEEP_ENABLE != 0) ? out_keep : {KEEP_WIDTH{1'b1}};
    assign m_axis_tlast  = (LAST_ENABLE != 0) ? out_last : 1'b0;
    assign m_axis_tvalid = out_valid;

endmodule

// File: rtl/emit.sv
// emit: prepends a SW-bit header struct to the head of a buffer stream.
//  Output beat 0 = {payload beat 0 << SW, struct}; every later beat carries the
//  SW bits spilled out of the previous payload beat. If the last payload beat
//  spills, one extra FLUSH beat carries the remainder.
// Ports: clk, rst (sync, active-high), s_struct_axis_* (header), s_inbuf_axis_*
//        (payload), m_outbuf_axis_* (emitted stream), state_dbg (FSM state),
//        pkt_count (packets emitted; only when EMIT_COUNT_EN is defined).
// Config macro: EMIT_COUNT_EN adds the pkt_count port and counter.
// Handshake: a beat transfers on a rising clk edge where tvalid & tready are both 1.
module emit
    import ep2_stream_pkg::*;
#(
    parameter int BUF_DATA_WIDTH       = DEF_DATA_WIDTH,
    parameter int BUF_KEEP_WIDTH       = BUF_DATA_WIDTH / 8,
    parameter int EMITTED_STRUCT_WIDTH = DEF_STRUCT_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [EMITTED_STRUCT_WIDTH-1:0] s_struct_axis_tdata,
    input  logic                      s_struct_axis_tvalid,
    output logic                      s_struct_axis_tready,
    input  logic [BUF_DATA_WIDTH-1:0] s_inbuf_axis_tdata,
    input  logic [BUF_KEEP_WIDTH-1:0] s_inbuf_axis_tkeep,
    input  logic                      s_inbuf_axis_tvalid,
    output logic                      s_inbuf_axis_tready,
    input  logic                      s_inbuf_axis_tlast,
    output logic [BUF_DATA_WIDTH-1:0] m_outbuf_axis_tdata,
    output logic [BUF_KEEP_WIDTH-1:0] m_outbuf_axis_tkeep,
    output logic                      m_outbuf_axis_tvalid,
    input  logic                      m_outbuf_axis_tready,
    output logic                      m_outbuf_axis_tlast,
    output emit_state_t               state_dbg
`ifdef EMIT_COUNT_EN
    ,
    output logic [31:0]               pkt_count
`endif
);

    localparam int DW = BUF_DATA_WIDTH;
    localparam int KW = BUF_KEEP_WIDTH;
    localparam int SW = EMITTED_STRUCT_WIDTH;
    localparam int SB = struct_bytes(SW);

    emit_state_t   state;
    logic [SW-1:0] carry;
    logic [SB-1:0] ckeep;

    logic          reg_s_tready;
    logic          out_rdy;
    logic          reg_valid;
    logic [DW-1:0] reg_data;
    logic [KW-1:0] reg_keep;
    logic          reg_last;
    logic          in_ovf;
    logic          fire;

    // Gating with rst keeps every tready low while reset is held.
    assign out_rdy = reg_s_tready & ~rst;
    // Set when this payload beat spills bytes past the top of the output beat.
    assign in_ovf  = keep_overflow(KEEP_MAX'(s_inbuf_axis_tkeep), KW, SB);
    assign fire    = reg_valid & out_rdy;

    always_comb begin
        s_struct_axis_tready = 1'b0;
        s_inbuf_axis_tready  = 1'b0;
        reg_valid            = 1'b0;
        reg_data             = {s_inbuf_axis_tdata[DW-SW-1:0], carry};
        reg_keep             = {s_inbuf_axis_tkeep[KW-SB-1:0], ckeep};
        reg_last             = s_inbuf_axis_tlast & ~in_ovf;
        case (state)
            IDLE: begin
                // Struct and first beat are only taken together.
                s_struct_axis_tready = s_inbuf_axis_tvalid & out_rdy;
                s_inbuf_axis_tready  = s_struct_axis_tvalid & out_rdy;
                reg_valid            = s_struct_axis_tvalid & s_inbuf_axis_tvalid;
                reg_data             = {s_inbuf_axis_tdata[DW-SW-1:0], s_struct_axis_tdata};
                reg_keep             = {s_inbuf_axis_tkeep[KW-SB-1:0], {SB{1'b1}}};
            end
            FORWARD: begin
                s_inbuf_axis_tready = out_rdy;
                reg_valid           = s_inbuf_axis_tvalid;
            end
            FLUSH: begin
                reg_valid = 1'b1;
                reg_data  = {{(DW-SW){1'b0}}, carry};
                reg_keep  = {{(KW-SB){1'b0}}, ckeep};
                reg_last  = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            carry <= '0;
            ckeep <= '0;
        end else if (fire) begin
            case (state)
                IDLE, FORWARD: begin
                    carry <= s_inbuf_axis_tdata[DW-1:DW-SW];
                    ckeep <= s_inbuf_axis_tkeep[KW-1:KW-SB];
                    if (!s_inbuf_axis_tlast) begin
                        state <= FORWARD;
                    end else if (in_ovf) begin
                        state <= FLUSH;
                    end else begin
                        state <= IDLE;
                    end
                end
                FLUSH:   state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign state_dbg = state;

    axis_register #(
        .DATA_WIDTH (DW),
        .KEEP_ENABLE(1),
        .KEEP_WIDTH (KW),
        .LAST_ENABLE(1),
        .REG_TYPE   (2)
    ) u_out_reg (
        .clk          (clk),
        .rst          (rst),
        .s_axis_tdata (reg_data),
        .s_axis_tkeep (reg_keep),
        .s_axis_tvalid(reg_valid),
        .s_axis_tready(reg_s_tready),
        .s_axis_tlast (reg_last),
        .m_axis_tdata (m_outbuf_axis_tdata),
        .m_axis_tkeep (m_outbuf_axis_tkeep),
        .m_axis_tvalid(m_outbuf_axis_tvalid),
        .m_axis_tready(m_outbuf_axis_tready),
        .m_axis_tlast (m_outbuf_axis_tlast)
    );

`ifdef EMIT_COUNT_EN
    logic [31:0] pkt_count_r;

    always_ff @(posedge clk) begin
        if (rst) begin
            pkt_count_r <= '0;
        end else if (m_outbuf_axis_tvalid && m_outbuf_axis_tready && m_outbuf_axis_tlast) begin
            pkt_count_r <= pkt_count_r + 32'd1;
        end
    end

    assign pkt_count = pkt_count_r;
`endif

endmodule

// File: tb/tb_emit.sv
// tb_emit: directed bench for emit (DW=256, SW=16).
// Expected output beats are built from a byte-level model of each packet
// (struct bytes followed by payload bytes, cut into 32-byte beats) and queued
// when the packet is driven; a monitor pops and compares on each output handshake.
module tb_emit;
    import ep2_stream_pkg::*;

    localparam int DW = 256;
    localparam int KW = 32;
    localparam int SW = 16;
    localparam int SB = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [SW-1:0] s_struct_tdata;
    logic          s_struct_tvalid;
    logic          s_struct_tready;
    logic [DW-1:0] s_inbuf_tdata;
    logic [KW-1:0] s_inbuf_tkeep;
    logic          s_inbuf_tvalid;
    logic          s_inbuf_tready;
    logic          s_inbuf_tlast;
    logic [DW-1:0] m_tdata;
    logic [KW-1:0] m_tkeep;
    logic          m_tvalid;
    logic          m_tready;
    logic          m_tlast;
    emit_state_t   state_dbg;
`ifdef EMIT_COUNT_EN
    logic [31:0]   pkt_count;
`endif

    logic rdy_toggle_en = 1'b0;
    logic rdy_phase     = 1'b0;
    logic rdy_force     = 1'b1;

    int errors = 0;
    int checks = 0;

    logic [DW-1:0] exp_data_q[$];
    logic [KW-1:0] exp_keep_q[$];
    logic          exp_last_q[$];

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) rdy_phase <= ~rdy_phase;
    assign m_tready = rdy_toggle_en ? rdy_phase : rdy_force;

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    emit dut (
        .clk                 (clk),
        .rst                 (rst),
        .s_struct_axis_tdata (s_struct_tdata),
        .s_struct_axis_tvalid(s_struct_tvalid),
        .s_struct_axis_tready(s_struct_tready),
        .s_inbuf_axis_tdata  (s_inbuf_tdata),
        .s_inbuf_axis_tkeep  (s_inbuf_tkeep),
        .s_inbuf_axis_tvalid (s_inbuf_tvalid),
        .s_inbuf_axis_tready (s_inbuf_tready),
        .s_inbuf_axis_tlast  (s_inbuf_tlast),
        .m_outbuf_axis_tdata (m_tdata),
        .m_outbuf_axis_tkeep (m_tkeep),
        .m_outbuf_axis_tvalid(m_tvalid),
        .m_outbuf_axis_tready(m_tready),
        .m_outbuf_axis_tlast (m_tlast),
        .state_dbg           (state_dbg)
`ifdef EMIT_COUNT_EN
        ,
        .pkt_count           (pkt_count)
`endif
    );

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: compare every output handshake against the queue head.
    always @(negedge clk) begin
        if (!rst && m_tvalid && m_tready) begin
            if (exp_data_q.size() == 0) begin
                check("unexpected_beat", 256'(1), 256'(0));
            end else begin
                check("beat_data", m_tdata, exp_data_q.pop_front());
                check("beat_keep", 256'(m_tkeep), 256'(exp_keep_q.pop_front()));
                check("beat_last", 256'(m_tlast), 256'(exp_last_q.pop_front()));
            end
        end
    end

    // Byte model: output = struct bytes (little end first) then payload bytes.
    task automatic push_expected(input logic [SW-1:0] st, input int n, input logic [7:0] base);
        int total, nbo, idx;
        logic [DW-1:0] d;
        logic [KW-1:0] k;
        total = n + SB;
        nbo   = (total + KW - 1) / KW;
        for (int b = 0; b < nbo; b++) begin
            d = '0;
            k = '0;
            for (int i = 0; i < KW; i++) begin
                idx = b * KW + i;
                if (idx < total) begin
                    if (idx < SB) d[i*8 +: 8] = st[idx*8 +: 8];
                    else          d[i*8 +: 8] = base + 8'(idx - SB);
                    k[i] = 1'b1;
                end
            end
            exp_data_q.push_back(d);
            exp_keep_q.push_back(k);
            exp_last_q.push_back(b == nbo - 1);
        end
    endtask

    // ---------------- drivers ----------------
    // Returns #1 after the edge on which the current payload beat transferred.
    task automatic wait_accept(input logic first_beat);
        int t;
        t = 0;
        forever begin
            @(negedge clk);
            if (s_inbuf_tready) begin
                if (first_beat) check("struct_ready_with_beat0", 256'(s_struct_tready), 256'(1));
                break;
            end
            t++;
            if (t > 200) begin
                check("accept_timeout", 256'(1), 256'(0));
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    // stop_after < 0 sends the whole packet; otherwise only that many beats.
    task automatic send_packet(input logic [SW-1:0] st, input int n, input logic [7:0] base,
                               input int stop_after);
        int nb;
        logic [DW-1:0] d;
        logic [KW-1:0] k;
        push_expected(st, n, base);
        nb = (n + KW - 1) / KW;
        s_struct_tdata  = st;
        s_struct_tvalid = 1'b1;
        for (int b = 0; b < nb; b++) begin
            if (stop_after >= 0 && b >= stop_after) break;
            d = '0;
            k = '0;
            for (int i = 0; i < KW; i++) begin
                if (b * KW + i < n) begin
                    d[i*8 +: 8] = base + 8'(b * KW + i);
                    k[i] = 1'b1;
                end
            end
            s_inbuf_tdata  = d;
            s_inbuf_tkeep  = k;
            s_inbuf_tlast  = (b == nb - 1);
            s_inbuf_tvalid = 1'b1;
            wait_accept(b == 0);
            s_struct_tvalid = 1'b0;
        end
        s_inbuf_tvalid = 1'b0;
        s_inbuf_tlast  = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_data_q.size() != 0 && t < 500) begin
            @(negedge clk);
            t++;
        end
        check("drain_pending", 256'(exp_data_q.size()), 256'(0));
        @(posedge clk);
        #1;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        rst             = 1'b1;
        s_struct_tdata  = '0;
        s_struct_tvalid = 1'b1;
        s_inbuf_tdata   = '0;
        s_inbuf_tkeep   = '0;
        s_inbuf_tvalid  = 1'b1;
        s_inbuf_tlast   = 1'b0;

        // Reset state: readies held low despite both valids high.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_struct_ready", 256'(s_struct_tready), 256'(0));
        check("rst_inbuf_ready", 256'(s_inbuf_tready), 256'(0));
        check("rst_m_valid", 256'(m_tvalid), 256'(0));
        @(posedge clk);
        #1;
        rst             = 1'b0;
        s_struct_tvalid = 1'b0;
        s_inbuf_tvalid  = 1'b0;
        @(negedge clk);
        check("post_rst_state", 256'(state_dbg), 256'(IDLE));
`ifdef EMIT_COUNT_EN
        check("post_rst_count", 256'(pkt_count), 256'(0));
`endif
        @(posedge clk);
        #1;

        // 1: single short beat
        send_packet(16'hBEEF, 10, 8'h10, -1);
        drain();

        // 2: single full beat spills into a flush beat
        send_packet(16'h1234, 32, 8'h40, -1);
        drain();

        // 3: 70-byte packet under toggling downstream ready
        rdy_toggle_en = 1'b1;
        send_packet(16'hA5C3, 70, 8'h80, -1);
        drain();
        rdy_toggle_en = 1'b0;

        // 4: struct offered alone is not taken
        s_struct_tdata  = 16'h5A5A;
        s_struct_tvalid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("lone_struct_ready", 256'(s_struct_tready), 256'(0));
        end
        @(posedge clk);
        #1;
        send_packet(16'h5A5A, 20, 8'h20, -1);
        drain();

        // 5: reset while in FORWARD
        send_packet(16'h7777, 70, 8'hC0, 2);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("mid_pkt_state", 256'(state_dbg), 256'(FORWARD));
        @(posedge clk);
        #1;
        rst             = 1'b1;
        s_struct_tvalid = 1'b1;
        s_inbuf_tvalid  = 1'b1;
        @(negedge clk);
        check("rst_fwd_inbuf_ready", 256'(s_inbuf_tready), 256'(0));
        check("rst_fwd_struct_ready", 256'(s_struct_tready), 256'(0));
        @(posedge clk);
        #1;
        rst             = 1'b0;
        s_struct_tvalid = 1'b0;
        s_inbuf_tvalid  = 1'b0;
        exp_data_q.delete();
        exp_keep_q.delete();
        exp_last_q.delete();
        @(negedge clk);
        check("after_rst_m_valid", 256'(m_tvalid), 256'(0));
        check("after_rst_state", 256'(state_dbg), 256'(IDLE));
        @(posedge clk);
        #1;
        send_packet(16'hBEEF, 10, 8'h10, -1);
        drain();

        // 6: back-to-back packets (64 bytes exercises the flush path)
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        send_packet(16'h0102, 10, 8'h00, -1);
        send_packet(16'h0304, 32, 8'h33, -1);
        send_packet(16'h0506, 70, 8'h66, -1);
        send_packet(16'h0708, 64, 8'h99, -1);
        drain();
`ifdef EMIT_COUNT_EN
        check("count_four", 256'(pkt_count), 256'(4));
        dut.pkt_count_r = 32'hFFFF_FFFF;
        send_packet(16'hBEEF, 10, 8'h10, -1);
        drain();
        check("count_wrap", 256'(pkt_count), 256'(0));
`endif

        check("final_queue_empty", 256'(exp_data_q.size()), 256'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
